// File: rtl/md_pkg.sv
// md_pkg: shared particle word layout and pair-queue FSM state
package md_pkg;
  localparam int PARTICLE_W = 114;
  localparam int ADDR_LSB = 105;
  localparam int CELL_LSB = 97;
  localparam int NULL_BIT = 96;
  localparam logic [PARTICLE_W-1:0] NULL_PARTICLE = PARTICLE_W'(1) << NULL_BIT;
  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} pq_state_t;
endpackage

// File: rtl/pair_queue_if.sv
// pair_queue_if: ring-node to force-pipeline pair handshake bundle
interface pair_queue_if #(parameter int PW = md_pkg::PARTICLE_W);
  logic [PW-1:0] ref_in;
  logic [PW-1:0] nbr_in;
  logic batch_start;
  logic done_batch;
  logic [2*PW-1:0] pair_out;
  logic pair_valid;
  logic pair_ready;
  logic full;
  logic overflow;
  logic drained;
  logic [15:0] pair_count;
  modport master (
    output ref_in, nbr_in, batch_start, done_batch, pair_ready,
    input pair_out, pair_valid, full, overflow, drained, pair_count
  );
  modport slave (
    input ref_in, nbr_in, batch_start, done_batch, pair_ready,
    output pair_out, pair_valid, full, overflow, drained, pair_count
  );
endinterface

// File: rtl/pair_fifo.sv
// pair_fifo: synchronous DEPTH x W FIFO; a push while full only lands alongside a pop
module pair_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 228
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/pair_queue.sv
// pair_queue: filters ring-node particle pairs into a FIFO and tracks batch progress
module pair_queue import md_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int PW = PARTICLE_W
) (
  input logic clk,
  input logic reset,
  pair_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH) + 1;
  pq_state_t state, state_next;
  logic [CW-1:0] occ;
  logic [2*PW-1:0] head;
  logic fifo_full, fifo_empty, self_pair, push, pop, ovf;
  logic [15:0] cnt;
  assign self_pair = q.ref_in[PW-1:ADDR_LSB] == q.nbr_in[PW-1:ADDR_LSB]
                  && q.ref_in[ADDR_LSB-1:CELL_LSB] == q.nbr_in[ADDR_LSB-1:CELL_LSB];
  assign push = state == ACCEPT && !q.ref_in[NULL_BIT] && !q.nbr_in[NULL_BIT] && !self_pair;
  assign q.pair_valid = (state == ACCEPT || state == DRAIN) && !fifo_empty;
  assign pop = q.pair_valid && q.pair_ready;
  assign q.pair_out = q.pair_valid ? head : {PW'(NULL_PARTICLE), PW'(NULL_PARTICLE)};
  assign q.full = fifo_full;
  assign q.overflow = ovf;
  assign q.pair_count = cnt;
  assign q.drained = state == DONE;
  pair_fifo #(.DEPTH(DEPTH), .W(2*PW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({q.ref_in, q.nbr_in}),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(occ)
  );
  // DRAIN only ever shrinks, so the queue empties exactly when occ equals this cycle's pop
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = q.batch_start ? ACCEPT : state;
      ACCEPT: state_next = q.done_batch ? DRAIN : ACCEPT;
      DRAIN: state_next = occ == CW'(pop) ? DONE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE || state == DONE) && q.batch_start) begin
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        if (push && fifo_full && !pop) ovf <= 1'b1;
        if (pop && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
    end
endmodule
